// File: rtl/serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// serial_mag_comparator
//
// Bit-serial WIDTH-bit unsigned magnitude comparator controller. On an
// accepted start it latches both operands and presents them MSB-first, one
// bit pair per cycle, on bit_a/bit_b to an external combinational 1-bit
// comparator stage. It folds that stage's bit_g/bit_l/bit_e answers into the
// final registered g/l/e result, and signals completion with busy/done.
//
// Optional build macro:
//   SERIAL_CMP_FULLSCAN_EN  - constant-time mode. Every compare scans all
//                             WIDTH bits. The first differing bit sets g/l
//                             and later bits are ignored.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   start          begin a compare (accepted only in IDLE)
//   a_in, b_in     unsigned operands, latched on an accepted start
//   bit_a, bit_b   current MSB pair driven to the 1-bit stage
//   bit_g/l/e      combinational answers from the 1-bit stage
//   busy           high while bits are being scanned
//   done           one-cycle pulse when g/l/e become valid
//   g, l, e        final A>B, A<B, A==B (held until next start or reset)
// ---------------------------------------------------------------------------
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             bit_a,
    output logic             bit_b,
    input  logic             bit_g,
    input  logic             bit_l,
    input  logic             bit_e,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             l,
    output logic             e
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sa_next;
    logic [WIDTH-1:0] sb_reg, sb_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             g_reg, g_next;
    logic             l_reg, l_next;
    logic             e_reg, e_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
`ifdef SERIAL_CMP_FULLSCAN_EN
    // Marks that a differing bit has already been seen in this scan.
    logic             decided_reg, decided_next;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sa_reg      <= '0;
            sb_reg      <= '0;
            cnt_reg     <= '0;
            g_reg       <= 1'b0;
            l_reg       <= 1'b0;
            e_reg       <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef SERIAL_CMP_FULLSCAN_EN
            decided_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            sa_reg      <= sa_next;
            sb_reg      <= sb_next;
            cnt_reg     <= cnt_next;
            g_reg       <= g_next;
            l_reg       <= l_next;
            e_reg       <= e_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
`ifdef SERIAL_CMP_FULLSCAN_EN
            decided_reg <= decided_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        sa_next      = sa_reg;
        sb_next      = sb_reg;
        cnt_next     = cnt_reg;
        g_next       = g_reg;
        l_next       = l_reg;
        e_next       = e_reg;
`ifdef SERIAL_CMP_FULLSCAN_EN
        decided_next = decided_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (start) begin
                    sa_next    = a_in;
                    sb_next    = b_in;
                    cnt_next   = CW'(WIDTH - 1);
                    g_next     = 1'b0;
                    l_next     = 1'b0;
                    e_next     = 1'b0;
`ifdef SERIAL_CMP_FULLSCAN_EN
                    decided_next = 1'b0;
`endif
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
`ifdef SERIAL_CMP_FULLSCAN_EN
                // Only the first non-equal bit pair sets the result. The stage
                // outputs are copied as-is even if they are not one-hot.
                if (!decided_reg && !bit_e) begin
                    g_next       = bit_g;
                    l_next       = bit_l;
                    decided_next = 1'b1;
                end
                if (cnt_reg == '0) begin
                    e_next     = !decided_reg && bit_e;
                    state_next = DONE;
                end else begin
                    sa_next  = sa_reg << 1;
                    sb_next  = sb_reg << 1;
                    cnt_next = cnt_reg - CW'(1);
                end
`else
                // Any pair not reported equal ends the scan. The stage
                // outputs are copied as-is even if they are not one-hot.
                if (!bit_e) begin
                    g_next     = bit_g;
                    l_next     = bit_l;
                    e_next     = 1'b0;
                    state_next = DONE;
                end else if (cnt_reg == '0) begin
                    g_next     = 1'b0;
                    l_next     = 1'b0;
                    e_next     = 1'b1;
                    state_next = DONE;
                end else begin
                    sa_next  = sa_reg << 1;
                    sb_next  = sb_reg << 1;
                    cnt_next = cnt_reg - CW'(1);
                end
`endif
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // busy and done are registered, so they follow the upcoming state.
        busy_next = (state_next == SHIFT);
        done_next = (state_next == DONE);
    end

    assign bit_a = sa_reg[WIDTH-1];
    assign bit_b = sb_reg[WIDTH-1];
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign g     = g_reg;
    assign l     = l_reg;
    assign e     = e_reg;

endmodule

// File: tb/tb_serial_mag_comparator.sv
module tb_serial_mag_comparator;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         bit_a, bit_b, bit_g, bit_l, bit_e;
    logic         busy, done, g, l, e;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural 1-bit comparator stage
    assign bit_g = bit_a & ~bit_b;
    assign bit_l = ~bit_a & bit_b;
    assign bit_e = ~(bit_a ^ bit_b);

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .bit_a (bit_a),
        .bit_b (bit_b),
        .bit_g (bit_g),
        .bit_l (bit_l),
        .bit_e (bit_e),
        .busy  (busy),
        .done  (done),
        .g     (g),
        .l     (l),
        .e     (e)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         eg;
        logic         el;
        logic         ee;
        int           lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: compares with arithmetic. The done cycle comes from the
    // position of the first differing bit, counted from the MSB.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic eg, output logic el, output logic ee,
                         output int lat);
        logic [W-1:0] x;
        int k;
        eg = (a > b);
        el = (a < b);
        ee = (a == b);
        x  = a ^ b;
        k  = W;
        for (int p = 0; p < W; p++)
            if (x[p]) k = W - p;
`ifdef SERIAL_CMP_FULLSCAN_EN
        lat = W + 1;
`else
        lat = ee ? W + 1 : k + 1;
`endif
    endtask

    // Issue a one-cycle start from IDLE and check the latency, the results
    // and the end of the done pulse.
    task automatic compare(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic eg, input logic el, input logic ee,
                           input int lat, input string name);
        int got;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);            // cycle 1
        start = 1'b0;
        got = 0;
        check({name, " busy_c1"}, int'(busy), 1);
        for (int c = 1; c <= W + 4; c++) begin
            if (done) begin
                got = c;
                break;
            end
            @(negedge clk);
        end
        check({name, " latency"}, got, lat);
        check({name, " g"}, int'(g), int'(eg));
        check({name, " l"}, int'(l), int'(el));
        check({name, " e"}, int'(e), int'(ee));
        @(negedge clk);
        check({name, " done_pulse_end"}, int'(done), 0);
        $display("compare a=%02h b=%02h latency=%0d g=%0d l=%0d e=%0d (%s)",
                 a, b, got, g, l, e, name);
    endtask

    initial begin
        int fs_lat;
        logic rg, rl, re;
        int rlat;
        logic [W-1:0] ra, rb;
        int got;
        int dcount;
        int dcyc[4];

`ifdef SERIAL_CMP_FULLSCAN_EN
        fs_lat = W + 1;
`else
        fs_lat = 0;
`endif
        vecs[0] = '{8'hA5, 8'h25, 1'b1, 1'b0, 1'b0, (fs_lat != 0) ? fs_lat : 2};
        vecs[1] = '{8'h3C, 8'h3D, 1'b0, 1'b1, 1'b0, 9};
        vecs[2] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 9};
        vecs[3] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, (fs_lat != 0) ? fs_lat : 2};
        vecs[4] = '{8'h01, 8'h02, 1'b0, 1'b1, 1'b0, (fs_lat != 0) ? fs_lat : 8};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 9};
        vecs[6] = '{8'h10, 8'h18, 1'b0, 1'b1, 1'b0, (fs_lat != 0) ? fs_lat : 6};

        // Reset held three cycles while start is asserted
        rst_n = 1'b0;
        start = 1'b1;
        a_in  = 8'hC3;
        b_in  = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst busy", int'(busy), 0);
            check("rst done", int'(done), 0);
            check("rst gle", int'({g, l, e}), 0);
            check("rst bits", int'({bit_a, bit_b}), 0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst idle", int'({busy, done}), 0);
        $display("reset sequence done");

        // Directed vector table
        foreach (vecs[i])
            compare(vecs[i].a, vecs[i].b, vecs[i].eg, vecs[i].el, vecs[i].ee,
                    vecs[i].lat, $sformatf("vec%0d", i));

        // Start while busy is ignored
        @(negedge clk);
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        start = 1'b1;
        @(negedge clk);            // cycle 1
        a_in  = 8'h00;
        b_in  = 8'h01;
        got = 0;
        for (int c = 1; c <= W + 4; c++) begin
            if (c == 4) start = 1'b0;
            if (done) begin
                got = c;
                break;
            end
            @(negedge clk);
        end
        check("busy_start latency", got, 9);
        check("busy_start gle", int'({g, l, e}), 3'b001);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_start hold", int'({busy, g, l, e}), 4'b0001);
        $display("start-while-busy: latency=%0d e=%0d", got, e);

        // Reset in the middle of a compare
        @(negedge clk);
        a_in  = 8'h80;
        b_in  = 8'h7F;
        start = 1'b1;
        @(negedge clk);            // cycle 1
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst done", int'(done), 0);
        check("midrst outs", int'({busy, g, l, e, bit_a, bit_b}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst no_done", int'({busy, done}), 0);
        $display("mid-compare reset checked");
        compare(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0,
                (fs_lat != 0) ? fs_lat : 2, "after_rst");

        // Back-to-back: start held high
        @(negedge clk);
        a_in  = 8'h01;
        b_in  = 8'h02;
        start = 1'b1;
        dcount = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin
                if (dcount < 4) dcyc[dcount] = c;
                dcount++;
                check($sformatf("b2b l%0d", dcount), int'({g, l, e}), 3'b010);
            end
        end
        start = 1'b0;
        rlat = (fs_lat != 0) ? fs_lat : 8;
        check("b2b count", dcount, (30 - rlat) / (rlat + 1) + 1);
        if (dcount >= 3) begin
            check("b2b first", dcyc[0], rlat);
            check("b2b second", dcyc[1], rlat + (rlat + 1));
            check("b2b third", dcyc[2], rlat + 2 * (rlat + 1));
        end
        $display("back-to-back: %0d done pulses", dcount);
        for (int i = 0; i < W + 4; i++) @(negedge clk);

        // Randomised pairs against the reference model
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = W'($urandom);
                1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = ra;
            endcase
            model(ra, rb, rg, rl, re, rlat);
            compare(ra, rb, rg, rl, re, rlat, $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
